// File: rtl/pitch_detector.sv
// Pitch detector: counts rising zero crossings with hysteresis over NUM_PERIODS periods,
// then a 32-step restoring divider turns the window's sample count into a frequency in Hz.
module pitch_detector #(
    parameter int unsigned SAMPLE_RATE = 131072,
    parameter int unsigned NUM_PERIODS = 4,
    parameter int unsigned HYST        = 8,
    parameter int unsigned MAX_COUNT   = 65535
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_in,
    input  logic [7:0]  data_in,
    output logic [31:0] freq_out,
    output logic        valid_out,
    output logic        busy_out
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DIV_W  = 17;
    localparam int unsigned PER_W  = 5;
    localparam int unsigned STEP_W = 5;
    localparam int unsigned QW     = 32;

    localparam logic [QW-1:0]     DIVIDEND = QW'(NUM_PERIODS * SAMPLE_RATE);
    localparam logic signed [7:0] HYST_P   = 8'(HYST);
    localparam logic signed [7:0] HYST_N   = 8'(256 - HYST);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_COUNT - 1);
    localparam logic [PER_W-1:0]  PER_LAST = PER_W'(NUM_PERIODS - 1);
    localparam logic [STEP_W-1:0] STEP_END = STEP_W'(QW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q;
    logic                armed_q;
    logic [CNT_W-1:0]    sample_cnt_q;
    logic [PER_W-1:0]    period_cnt_q;
    logic [DIV_W-1:0]    divisor_q;
    logic [DIV_W-1:0]    rem_q;
    logic [QW-1:0]       quo_q;
    logic [STEP_W-1:0]   step_q;

    logic signed [7:0]   data_s;
    logic                arm_c;
    logic                cross_c;
    logic [DIV_W:0]      shift_c;
    logic [DIV_W:0]      diff_c;
    logic                fits_c;

    // Hysteresis: a rising crossing needs a dip to -HYST followed by a rise to +HYST
    assign data_s  = $signed(data_in);
    assign arm_c   = sample_in && (data_s <= HYST_N);
    assign cross_c = sample_in && armed_q && (data_s >= HYST_P);

    // Restoring divider step: the dividend shifts out of quo_q as quotient bits shift in
    assign shift_c = {rem_q, quo_q[QW-1]};
    assign fits_c  = shift_c >= {1'b0, divisor_q};
    assign diff_c  = shift_c - {1'b0, divisor_q};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            sample_cnt_q <= '0;
            period_cnt_q <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            freq_out     <= '0;
            valid_out    <= 1'b0;
            busy_out     <= 1'b0;
        end else begin
            valid_out <= 1'b0;

            if (arm_c) begin
                armed_q <= 1'b1;
            end else if (cross_c) begin
                armed_q <= 1'b0;
            end

            // Window counters keep running through DIVIDE and DONE
            if (state_q != IDLE && sample_in) begin
                sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            end
            if (state_q != IDLE && cross_c) begin
                period_cnt_q <= period_cnt_q + PER_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (cross_c) begin
                        sample_cnt_q <= '0;
                        period_cnt_q <= '0;
                        state_q      <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (cross_c && period_cnt_q == PER_LAST) begin
                        // Terminating crossing also opens the next window
                        divisor_q    <= DIV_W'(sample_cnt_q) + DIV_W'(1);
                        sample_cnt_q <= '0;
                        period_cnt_q <= '0;
                        rem_q        <= '0;
                        quo_q        <= DIVIDEND;
                        step_q       <= '0;
                        busy_out     <= 1'b1;
                        state_q      <= DIVIDE;
                    end else if (sample_in && sample_cnt_q == CNT_LAST) begin
                        freq_out  <= '0;
                        valid_out <= 1'b1;
                        armed_q   <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DIVIDE: begin
                    rem_q  <= fits_c ? DIV_W'(diff_c) : DIV_W'(shift_c);
                    quo_q  <= {quo_q[QW-2:0], fits_c};
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_END) begin
                        busy_out <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    freq_out  <= quo_q;
                    valid_out <= 1'b1;
                    state_q   <= MEASURE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pitch_detector.sv
// Directed bench for pitch_detector: square waves, sine, timeout, reset during divide, slow strobes.
module tb_pitch_detector;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        sample_in;
    logic [7:0]  data_in;
    logic [31:0] freq_out;
    logic        valid_out;
    logic        busy_out;

    int errors = 0;
    int checks = 0;

    int          cyc = 0;
    int          cross_cyc = 0;
    logic        m_armed = 1'b0;
    logic        prev_valid = 1'b0;
    bit          consec = 1'b0;
    int          vcnt = 0;
    logic [31:0] vfreq [0:15];
    int          vlat  [0:15];

    pitch_detector dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sample_in (sample_in),
        .data_in   (data_in),
        .freq_out  (freq_out),
        .valid_out (valid_out),
        .busy_out  (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference crossing tracker and valid_out recorder (sampled 1 ns after the edge)
    always @(posedge clk_in) begin
        if (rst_in) begin
            m_armed = 1'b0;
        end else if (sample_in) begin
            if ($signed(data_in) <= -8) begin
                m_armed = 1'b1;
            end else if (m_armed && $signed(data_in) >= 8) begin
                m_armed   = 1'b0;
                cross_cyc = cyc;
            end
        end
        cyc++;
        #1;
        if (valid_out) begin
            if (prev_valid) consec = 1'b1;
            vfreq[vcnt % 16] = freq_out;
            vlat[vcnt % 16]  = cyc - cross_cyc;
            vcnt++;
        end
        prev_valid = valid_out;
    end

    task automatic send(input int d, input int gap);
        sample_in = 1'b1;
        data_in   = 8'(d);
        @(negedge clk_in);
        sample_in = 1'b0;
        repeat (gap) @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in    = 1'b1;
        sample_in = 1'b0;
        data_in   = 8'd0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic sq_periods(input int half, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < half; i++) send(100, 0);
            for (int i = 0; i < half; i++) send(-100, 0);
        end
    endtask

    // Period-4 square producing n rising crossings, ending on the n-th crossing sample
    task automatic pulses(input int n, input int gap);
        send(-100, gap);
        send(-100, gap);
        send(100, gap);
        for (int i = 1; i < n; i++) begin
            send(100, gap);
            send(-100, gap);
            send(-100, gap);
            send(100, gap);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    endtask

    task automatic test_square_256();
        int base;
        base = vcnt;
        for (int i = 0; i < 128; i++) send(-100, 0);
        sq_periods(128, 9);
        repeat (5) @(negedge clk_in);
        checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL sq256_count: got %0d want 2", vcnt - base); end
        checks++; if (vfreq[base % 16] !== 32'd512) begin errors++; $display("FAIL sq256_freq0: got %0d want 512", vfreq[base % 16]); end
        checks++; if (vfreq[(base + 1) % 16] !== 32'd512) begin errors++; $display("FAIL sq256_freq1: got %0d want 512", vfreq[(base + 1) % 16]); end
        checks++; if (freq_out !== 32'd512) begin errors++; $display("FAIL sq256_hold: got %0d want 512", freq_out); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = vcnt;
        for (int i = 0; i < 150; i++) send(-100, 0);
        sq_periods(150, 9);
        repeat (5) @(negedge clk_in);
        checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL sq300_count: got %0d want 2", vcnt - base); end
        checks++; if (vfreq[base % 16] !== 32'd436) begin errors++; $display("FAIL sq300_freq0: got %0d want 436", vfreq[base % 16]); end
        checks++; if (vfreq[(base + 1) % 16] !== 32'd436) begin errors++; $display("FAIL sq300_freq1: got %0d want 436", vfreq[(base + 1) % 16]); end
        checks++; if (vlat[(base + 1) % 16] !== 34) begin errors++; $display("FAIL sq300_latency: got %0d want 34", vlat[(base + 1) % 16]); end
    endtask

    task automatic test_reset_mid_divide();
        int base;
        pulses(4, 0);
        repeat (10) @(negedge clk_in);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL middiv_busy_before: got %b want 1", busy_out); end
        base = vcnt;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL middiv_freq: got %0d want 0", freq_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL middiv_busy: got %b want 0", busy_out); end
        repeat (40) @(negedge clk_in);
        checks++; if (vcnt !== base) begin errors++; $display("FAIL middiv_no_valid: got %0d pulses want 0", vcnt - base); end
        pulses(5, 0);
        repeat (40) @(negedge clk_in);
        checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL middiv_restart_count: got %0d want 1", vcnt - base); end
        checks++; if (freq_out !== 32'd32768) begin errors++; $display("FAIL middiv_restart_freq: got %0d want 32768", freq_out); end
    endtask

    task automatic test_sine();
        int base;
        int v;
        do_reset();
        base = vcnt;
        for (int n = 0; n < 4000 && (vcnt - base) < 2; n++) begin
            v = $rtoi($floor(100.0 * $sin(6.283185307179586 * 440.0 * real'(n) / 131072.0) + 0.5));
            send(v, 0);
        end
        checks++;
        if (vcnt - base < 2) begin
            errors++; $display("FAIL sine_timeout: got %0d pulses want 2", vcnt - base);
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (vfreq[(base + k) % 16] !== 32'd439 && vfreq[(base + k) % 16] !== 32'd440) begin
                    errors++; $display("FAIL sine_freq%0d: got %0d want 439 or 440", k, vfreq[(base + k) % 16]);
                end
                checks++;
                if (vlat[(base + k) % 16] !== 34) begin
                    errors++; $display("FAIL sine_latency%0d: got %0d want 34", k, vlat[(base + k) % 16]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = vcnt;
        pulses(5, 0);
        for (int k = 1; k < 65535; k++) send(((k * 7) % 11) - 5, 0);
        checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL tmo_early: got %0d want 1", vcnt - base); end
        checks++; if (freq_out !== 32'd32768) begin errors++; $display("FAIL tmo_prev_freq: got %0d want 32768", freq_out); end
        send(3, 0);
        checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL tmo_count: got %0d want 2", vcnt - base); end
        checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL tmo_freq: got %0d want 0", freq_out); end
        // Back in IDLE: the first crossing only starts a window, so four crossings complete nothing
        pulses(4, 0);
        repeat (40) @(negedge clk_in);
        checks++; if (vcnt - base !== 2) begin errors++; $display("FAIL tmo_idle: got %0d want 2", vcnt - base); end
    endtask

    task automatic test_slow();
        int base;
        do_reset();
        base = vcnt;
        pulses(5, 762);
        checks++; if (vcnt - base !== 1) begin errors++; $display("FAIL slow_count: got %0d want 1", vcnt - base); end
        checks++; if (freq_out !== 32'd32768) begin errors++; $display("FAIL slow_freq: got %0d want 32768", freq_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL slow_busy: got %b want 0", busy_out); end
        checks++; if (vlat[base % 16] !== 34) begin errors++; $display("FAIL slow_latency: got %0d want 34", vlat[base % 16]); end
    endtask

    initial begin
        rst_in    = 1'b1;
        sample_in = 1'b0;
        data_in   = 8'd0;
        @(negedge clk_in);
        test_reset();
        test_square_256();
        test_back_to_back();
        test_reset_mid_divide();
        test_sine();
        test_timeout();
        test_slow();
        checks++; if (consec !== 1'b0) begin errors++; $display("FAIL valid_consecutive: got %b want 0", consec); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
